// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operation sequencer: data width,
// opcode constants, FSM state encoding and an opcode legality helper.
package calc_pkg;

    localparam int DATA_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NEG = 3'b010;
    localparam logic [2:0] OP_ABS = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_MUL_IT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // ADD..ABS are always legal; MUL only when the multiplier is enabled.
    function automatic logic op_legal(input logic [2:0] op, input logic mul_en);
        logic ok;
        ok = 1'b0;
        if (op <= OP_ABS) begin
            ok = 1'b1;
        end else if (op == OP_MUL) begin
            ok = mul_en;
        end
        return ok;
    endfunction

endpackage

// File: rtl/AddSub4.sv
// Shared 4-bit two's complement adder/subtractor.
// Cin=1 selects subtraction: S = A + ~B + 1, otherwise S = A + B.
module AddSub4
    import calc_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Cin,
    output logic [DATA_W-1:0] S,
    output logic              ovf
);

    logic [DATA_W-1:0] w_b_eff;

    // Conditionally invert B and add; signed overflow when both addend signs
    // agree but the sum sign differs.
    always_comb begin
        w_b_eff = Cin ? ~B : B;
        S       = A + w_b_eff + {{(DATA_W-1){1'b0}}, Cin};
        ovf     = (A[DATA_W-1] == w_b_eff[DATA_W-1]) && (S[DATA_W-1] != A[DATA_W-1]);
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Multi-cycle controller time-sharing one AddSub4 datapath for
// ADD, SUB, NEG, ABS and MUL (repeated addition).
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output logic              err
);

    state_t            r_state;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic              r_ovf_acc;
    logic [DATA_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_result;
    logic              r_ovf;
    logic              r_err;

    logic [DATA_W-1:0] w_dp_a;
    logic [DATA_W-1:0] w_dp_b;
    logic              w_dp_cin;
    logic [DATA_W-1:0] w_dp_s;
    logic              w_dp_ovf;
    logic [DATA_W-1:0] w_abs_b;
    logic              w_op_legal;

    AddSub4 u_dp (
        .A   (w_dp_a),
        .B   (w_dp_b),
        .Cin (w_dp_cin),
        .S   (w_dp_s),
        .ovf (w_dp_ovf)
    );

    // Datapath operand mux. In IDLE the adder is otherwise unused, so it
    // negates the incoming b to form the MUL iteration count.
    always_comb begin
        w_dp_a   = '0;
        w_dp_b   = r_b;
        w_dp_cin = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_dp_a   = '0;
                w_dp_b   = b;
                w_dp_cin = 1'b1;
            end
            ST_EXEC: begin
                case (r_op)
                    OP_ADD: begin
                        w_dp_a   = r_a;
                        w_dp_cin = 1'b0;
                    end
                    OP_SUB: begin
                        w_dp_a   = r_a;
                        w_dp_cin = 1'b1;
                    end
                    default: begin
                        // NEG, and ABS of a negative value
                        w_dp_a   = '0;
                        w_dp_cin = 1'b1;
                    end
                endcase
            end
            ST_MUL_IT: begin
                // Accumulate +a for non-negative multiplier, -a for negative.
                w_dp_a   = r_acc;
                w_dp_b   = r_a;
                w_dp_cin = r_b[DATA_W-1];
            end
            default: begin
                w_dp_a   = '0;
                w_dp_b   = r_b;
                w_dp_cin = 1'b0;
            end
        endcase
    end

    // Iteration count |b|; -8 wraps to 1000 which reads as unsigned 8.
    always_comb begin
        w_abs_b    = b[DATA_W-1] ? w_dp_s : b;
        w_op_legal = op_legal(op, MUL_EN);
    end

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_ADD;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_a    <= a;
                        r_b    <= b;
                        r_busy <= 1'b1;
                        if (!w_op_legal) begin
                            // Illegal opcode keeps the previous result and ovf.
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (op == OP_MUL) begin
                            if (w_abs_b == '0) begin
                                r_result <= '0;
                                r_ovf    <= 1'b0;
                                r_err    <= 1'b0;
                                r_done   <= 1'b1;
                                r_state  <= ST_DONE;
                            end else begin
                                r_cnt     <= w_abs_b;
                                r_acc     <= '0;
                                r_ovf_acc <= 1'b0;
                                r_state   <= ST_MUL_IT;
                            end
                        end else begin
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_op == OP_ABS && !r_b[DATA_W-1]) begin
                        r_result <= r_b;
                        r_ovf    <= 1'b0;
                    end else begin
                        r_result <= w_dp_s;
                        r_ovf    <= w_dp_ovf;
                    end
                    r_err   <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_MUL_IT: begin
                    // Partial sums grow monotonically, so a sticky overflow
                    // matches overflow of the final product.
                    r_acc     <= w_dp_s;
                    r_ovf_acc <= r_ovf_acc | w_dp_ovf;
                    r_cnt     <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_result <= w_dp_s;
                        r_ovf    <= r_ovf_acc | w_dp_ovf;
                        r_err    <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign ovf    = r_ovf;
    assign err    = r_err;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: directed cases followed by
// random requests, compared against an arithmetic reference model.
module tb_calc_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       ovf;
    logic       err;

    int errors = 0;
    int checks = 0;
    int txn_no = 0;

    // Reference state: last delivered result/ovf (illegal ops keep them).
    logic [3:0] m_result = 4'd0;
    logic       m_ovf    = 1'b0;

    calc_op_sequencer #(.MUL_EN(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Issue one request at a negedge and follow it to completion.
    task automatic run_op(input logic [2:0] t_op, input logic [3:0] t_a,
                          input logic [3:0] t_b, input bit noise);
        int p;
        int sa;
        int sb;
        int exp_lat;
        int n;
        logic [3:0] e_res;
        logic       e_ovf;
        logic       e_err;

        sa = sx4(t_a);
        sb = sx4(t_b);
        p  = 0;
        e_err = 1'b0;
        case (t_op)
            3'd0: p = sa + sb;
            3'd1: p = sa - sb;
            3'd2: p = -sb;
            3'd3: p = (sb < 0) ? -sb : sb;
            3'd4: p = sa * sb;
            default: e_err = 1'b1;
        endcase
        if (e_err) begin
            e_res   = m_result;
            e_ovf   = m_ovf;
            exp_lat = 1;
        end else begin
            e_res = p[3:0];
            e_ovf = (p > 7) || (p < -8);
            if (t_op == 3'd4) exp_lat = ((sb < 0) ? -sb : sb) + 1;
            else              exp_lat = 2;
        end

        op = t_op; a = t_a; b = t_b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            chk("busy_during", busy, 1'b1);
            // Mid-operation disturbance: stray starts and new operands.
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                op    = 3'($urandom_range(0, 7));
                a     = 4'($urandom_range(0, 15));
                b     = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", n, exp_lat);
        chk("busy_at_done", busy, 1'b1);
        chk("result", result, e_res);
        chk("ovf", ovf, e_ovf);
        chk("err", err, e_err);
        $display("txn %0d op=%0d a=%0d b=%0d result=%b ovf=%b err=%b latency=%0d noise=%0d",
                 txn_no, t_op, sa, sb, result, ovf, err, n, noise);
        txn_no++;
        m_result = e_res;
        m_ovf    = e_ovf;
        // A start still held through the DONE cycle must be ignored.
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse_len", done, 1'b0);
        chk("busy_after", busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = 4'd0;
        b     = 4'd0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 4'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(3'd0, 4'd3,  4'd2,  1'b0);   // ADD 3+2
        run_op(3'd1, 4'h8,  4'd1,  1'b0);   // SUB -8-1
        run_op(3'd3, 4'd0,  4'h8,  1'b0);   // ABS -8
        run_op(3'd3, 4'd0,  4'd5,  1'b0);   // ABS 5
        run_op(3'd2, 4'd0,  4'h8,  1'b0);   // NEG -8
        run_op(3'd4, 4'd3,  4'hE,  1'b0);   // MUL 3*-2
        run_op(3'd4, 4'h8,  4'hF,  1'b0);   // MUL -8*-1
        run_op(3'd4, 4'd3,  4'd0,  1'b0);   // MUL 3*0
        run_op(3'd4, 4'd2,  4'h8,  1'b1);   // MUL 2*-8 with stray starts
        run_op(3'd6, 4'd1,  4'd1,  1'b0);   // illegal
        run_op(3'd0, 4'd7,  4'd1,  1'b0);   // legal op clears err
        run_op(3'd4, 4'd7,  4'd7,  1'b1);   // MUL 7*7 with stray starts

        // Reset in the middle of a long MUL
        op = 3'd4; a = 4'd2; b = 4'h8; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_result", result, 4'd0);
        chk("abort_ovf", ovf, 1'b0);
        chk("abort_err", err, 1'b0);
        m_result = 4'd0;
        m_ovf    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end
        run_op(3'd0, 4'd4, 4'd5, 1'b0);     // ADD after abort

        // Random requests
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
